seg7_multi_counter: RTL and testbench
=====================================

Name: seg7_multi_counter

Overview:
- Parametrised successor to the team's fixed dual-counter, mux and hex 7-segment tile.
- Holds NUM_CH modulo-MODULUS counters with:
  - per-channel enable
  - up/down direction
  - prescaled stepping
  - independent or cascaded (multi-digit) mode
  - synchronous load
- Displays one channel on a 7-segment output, either by direct select or by auto-scan.
- Sits between the top-level ui_in/uo_out pins and the counter core.

Parameters:
- NUM_CH, 4: number of counter channels (2..8).
- CNT_W, 4: counter width in bits (1..4; decoder shows hex 0-F).
- MODULUS, 10: counter modulus; values run 0..MODULUS-1; 2 <= MODULUS <= 2**CNT_W.
- PRESC_DIV, 1: clocks per count tick (1 = tick every clock).
- SCAN_DIV, 4: clocks each channel is displayed in scan mode (>= 1).
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  global count enable; gates the prescaler as well.
- ch_en  in  NUM_CH  per-channel enable (independent mode only).
- up_dn  in  1  1 = count up, 0 = count down.
- cascade  in  1  1 = channels chained as digits, ch0 least significant.
- load  in  1  synchronous load strobe.
- load_ch  in  SW  channel to load; SW = max(1, clog2(NUM_CH)).
- load_val  in  CNT_W  value to load.
- scan_en  in  1  1 = auto-scan display, 0 = display channel sel.
- sel  in  SW  displayed channel when scan_en=0.
- seg  out  7  segments a..g on seg[0]..seg[6]; registered.
- dp  out  1  decimal point; registered.
- digit_idx  out  SW  index of the channel currently shown; registered.
- carry_out  out  1  one-clock pulse on wrap of top channel NUM_CH-1.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Counters, prescaler and scan index go to 0.
  - seg = blank, dp = off, digit_idx = 0, carry_out = 0.
  - Reset overrides every other input, including mid-count and mid-load.
- Prescaler:
  - Counts 0..PRESC_DIV-1 while en=1; holds while en=0.
  - tick = en AND prescaler == PRESC_DIV-1.
  - Prescaler is not reset by load or by a mode change.
- Step rule for a channel on a step:
  - Up: value+1; MODULUS-1 goes to 0 (wrap).
  - Down: value-1; 0 goes to MODULUS-1 (wrap).
- Independent mode (cascade=0): on tick, every channel with ch_en[c]=1 steps. Channels do not interact.
- Cascade mode (cascade=1): ch_en is ignored.
  - ch0 steps on tick.
  - ch c (c>0) steps in the same clock when ch c-1 steps and wraps.
  - This is a combinational ripple; all channels update on the same edge.
- carry_out is registered and equals 1 for exactly the clock after any edge where ch NUM_CH-1 stepped and wrapped, in either mode.
- Load:
  - load=1 writes load_val into channel load_ch at the edge.
  - If load_val >= MODULUS, MODULUS-1 is stored.
  - load_ch >= NUM_CH: no effect.
  - Load beats a step on the same channel in the same clock. Other channels step normally.
  - In cascade mode a loaded channel does not produce a wrap, so higher channels hold unless they are stepping for another reason.
- Display selection:
  - scan_en=0: displayed index = sel. sel >= NUM_CH gives blank seg and dp off.
  - scan_en=1: scan index advances every SCAN_DIV clocks, 0..NUM_CH-1 then back to 0.
  - Scan index holds when scan_en=0.
- Display latency: seg, dp and digit_idx are registered and reflect counter/select state one clock later.
- Hex decode, gfedcba, active-high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- dp is lit when the displayed value == MODULUS-1 (terminal count).
- SEG_ACTIVE_LOW=1 inverts seg and dp at the output; "blank" is then 7'h7F.

Test Plan (defaults unless stated: NUM_CH=4, CNT_W=4, MODULUS=10, PRESC_DIV=1):
- rst pulse, then en=1, ch_en=0001, up_dn=1, cascade=0, sel=0 for 3 clocks → ch0=3; seg=0x4F on the 4th edge; other channels stay 0.
- cascade=1, load all channels to 9 (4 load clocks), en=1 for one tick →
  - all channels 0, seg(sel=0)=0x3F;
  - carry_out=1 for exactly one clock.
- up_dn=0, ch0=0, one tick → ch0=9, seg=0x6F, dp=1.
- Load and out-of-range select:
  - load=1, load_ch=2, load_val=12 during a tick with ch_en[2]=1 → ch2=9 (saturate; load wins over step).
  - Then sel=2 → seg=0x6F.
- NUM_CH=3, sel=3, scan_en=0 → seg=0x00, dp=0.
- Scan, then mid-count reset:
  - scan_en=1, SCAN_DIV=2 → digit_idx sequence 0,0,1,1,2,2,0.
  - rst mid-count → all outputs at reset values the next clock.

Source files
------------

// File: rtl/seg7_multi_counter.sv
// Bank of NUM_CH modulo counters (independent or cascaded as digits) with a
// registered hex 7-segment view of one channel, chosen directly or by auto-scan.
module seg7_multi_counter #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 4,
    parameter int MODULUS        = 10,
    parameter int PRESC_DIV      = 1,
    parameter int SCAN_DIV       = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    localparam int SW            = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              up_dn,
    input  logic              cascade,
    input  logic              load,
    input  logic [SW-1:0]     load_ch,
    input  logic [CNT_W-1:0]  load_val,
    input  logic              scan_en,
    input  logic [SW-1:0]     sel,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [SW-1:0]     digit_idx,
    output logic              carry_out
);

    localparam int PW  = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int SDW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC_DIV - 1);
    localparam logic [SDW-1:0]   SCAN_LAST  = SDW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]    CH_LAST    = SW'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] TERM       = CNT_W'(MODULUS - 1);
    localparam logic [CNT_W:0]   MOD_EXT    = (CNT_W + 1)'(MODULUS);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [PW-1:0]    presc_reg;
    logic             tick;
    logic [CNT_W-1:0] cnt_reg  [NUM_CH];
    logic [CNT_W-1:0] cnt_next [NUM_CH];
    logic [NUM_CH-1:0] at_end;
    logic [NUM_CH-1:0] load_hit;
    logic [NUM_CH-1:0] step;
    logic [NUM_CH-1:0] wrap;
    logic             ripple;
    logic [CNT_W-1:0] load_sat;
    logic             carry_reg;

    logic [SDW-1:0]   scan_div_reg;
    logic [SW-1:0]    scan_idx_reg;
    logic [SW-1:0]    disp_idx;
    logic             disp_hit;
    logic [CNT_W-1:0] disp_val;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [SW-1:0]    digit_idx_reg;

    assign tick     = en && (presc_reg == PRESC_LAST);
    assign load_sat = ({1'b0, load_val} >= MOD_EXT) ? TERM : load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (en) begin
            presc_reg <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
        end
    end

    // Step/wrap chain: in cascade mode each wrap feeds the next channel's step
    // in the same cycle; a loaded channel never passes a wrap upward.
    always_comb begin
        step   = '0;
        wrap   = '0;
        ripple = tick;
        for (int i = 0; i < NUM_CH; i++) begin
            step[i] = cascade ? ripple : (tick & ch_en[i]);
            wrap[i] = step[i] & at_end[i] & ~load_hit[i];
            ripple  = wrap[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign at_end[gi]   = up_dn ? (cnt_reg[gi] == TERM) : (cnt_reg[gi] == '0);
            assign load_hit[gi] = load && (load_ch == SW'(gi));
            assign cnt_next[gi] = load_hit[gi] ? load_sat :
                                  !step[gi]    ? cnt_reg[gi] :
                                  at_end[gi]   ? (up_dn ? '0 : TERM) :
                                  up_dn        ? cnt_reg[gi] + CNT_W'(1) :
                                                 cnt_reg[gi] - CNT_W'(1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '{default: '0};
            carry_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            carry_reg <= wrap[NUM_CH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_div_reg <= '0;
            scan_idx_reg <= '0;
        end else if (scan_en) begin
            if (scan_div_reg == SCAN_LAST) begin
                scan_div_reg <= '0;
                scan_idx_reg <= (scan_idx_reg == CH_LAST) ? '0 : scan_idx_reg + SW'(1);
            end else begin
                scan_div_reg <= scan_div_reg + SDW'(1);
            end
        end
    end

    // An index with no matching channel leaves disp_hit low, which blanks the digit.
    always_comb begin
        disp_idx = scan_en ? scan_idx_reg : sel;
        disp_hit = 1'b0;
        disp_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (disp_idx == SW'(i)) begin
                disp_hit = 1'b1;
                disp_val = cnt_reg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg       <= '0;
            dp_reg        <= 1'b0;
            digit_idx_reg <= '0;
        end else begin
            seg_reg       <= disp_hit ? hex7(4'(disp_val)) : 7'h00;
            dp_reg        <= disp_hit && (disp_val == TERM);
            digit_idx_reg <= disp_idx;
        end
    end

    assign seg       = (SEG_ACTIVE_LOW != 0) ? ~seg_reg : seg_reg;
    assign dp        = (SEG_ACTIVE_LOW != 0) ? ~dp_reg  : dp_reg;
    assign digit_idx = digit_idx_reg;
    assign carry_out = carry_reg;

endmodule

// File: tb/tb_seg7_multi_counter.sv
// Scoreboard bench: stimulus queues expected output values tagged with the
// cycle they are due; a monitor compares them against two DUT configurations.
module tb_seg7_multi_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] ch_en;
    logic       up_dn;
    logic       cascade;
    logic       load;
    logic [1:0] load_ch;
    logic [3:0] load_val;
    logic       scan_en;
    logic [1:0] sel;

    logic [6:0] seg4, seg3;
    logic       dp4, dp3;
    logic [1:0] dig4, dig3;
    logic       carry4, carry3;

    seg7_multi_counter #(
        .NUM_CH(4), .CNT_W(4), .MODULUS(10), .PRESC_DIV(1), .SCAN_DIV(2), .SEG_ACTIVE_LOW(0)
    ) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .up_dn(up_dn), .cascade(cascade),
        .load(load), .load_ch(load_ch), .load_val(load_val), .scan_en(scan_en), .sel(sel),
        .seg(seg4), .dp(dp4), .digit_idx(dig4), .carry_out(carry4)
    );

    seg7_multi_counter #(
        .NUM_CH(3), .CNT_W(4), .MODULUS(10), .PRESC_DIV(1), .SCAN_DIV(2), .SEG_ACTIVE_LOW(0)
    ) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .ch_en(ch_en[2:0]), .up_dn(up_dn), .cascade(cascade),
        .load(load), .load_ch(load_ch), .load_val(load_val), .scan_en(scan_en), .sel(sel),
        .seg(seg3), .dp(dp3), .digit_idx(dig3), .carry_out(carry3)
    );

    typedef struct {
        int         due;
        int         sig;
        logic [7:0] exp;
        string      name;
    } exp_t;

    localparam int S_SEG4 = 0, S_DP4 = 1, S_DIG4 = 2, S_CRY4 = 3;
    localparam int S_SEG3 = 4, S_DP3 = 5, S_DIG3 = 6, S_CRY3 = 7;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input int sig);
        case (sig)
            S_SEG4:  actual = {1'b0, seg4};
            S_DP4:   actual = {7'b0, dp4};
            S_DIG4:  actual = {6'b0, dig4};
            S_CRY4:  actual = {7'b0, carry4};
            S_SEG3:  actual = {1'b0, seg3};
            S_DP3:   actual = {7'b0, dp3};
            S_DIG3:  actual = {6'b0, dig3};
            default: actual = {7'b0, carry3};
        endcase
    endfunction

    task automatic expect_at(input int delay, input int sig, input logic [7:0] v, input string nm);
        exp_t e;
        e.due  = cyc + delay;
        e.sig  = sig;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every negedge, retire all expectations due after the latest edge.
    initial begin
        logic [7:0] act;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    act = actual(sb[i].sig);
                    checks++;
                    if (act !== sb[i].exp) begin
                        failures++;
                        $display("FAIL %s cyc=%0d actual=0x%02h required=0x%02h",
                                 sb[i].name, cyc, act, sb[i].exp);
                    end else begin
                        $display("ok   %s cyc=%0d value=0x%02h", sb[i].name, cyc, act);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; ch_en = 4'b0; up_dn = 1'b1; cascade = 1'b0;
        load = 1'b0; load_ch = 2'd0; load_val = 4'd0; scan_en = 1'b0; sel = 2'd0;

        // Reset state
        nclk(1);
        checks++;
        if (seg4 !== 7'h00) begin
            failures++;
            $display("FAIL direct_rst_seg4 actual=0x%02h required=0x00", seg4);
        end else begin
            $display("ok   direct_rst_seg4 value=0x%02h", seg4);
        end
        checks++;
        if (carry4 !== 1'b0) begin
            failures++;
            $display("FAIL direct_rst_carry4 actual=%0b required=0", carry4);
        end else begin
            $display("ok   direct_rst_carry4 value=%0b", carry4);
        end
        expect_at(1, S_SEG4, 8'h00, "rst_seg4");
        expect_at(1, S_DP4,  8'h00, "rst_dp4");
        expect_at(1, S_DIG4, 8'h00, "rst_dig4");
        expect_at(1, S_CRY4, 8'h00, "rst_carry4");
        expect_at(1, S_SEG3, 8'h00, "rst_seg3");
        nclk(1);
        checks++;
        if (dig4 !== 2'd0) begin
            failures++;
            $display("FAIL direct_rst_dig4 actual=%0d required=0", dig4);
        end else begin
            $display("ok   direct_rst_dig4 value=%0d", dig4);
        end
        rst = 1'b0;

        // Independent up-count of ch0 for three ticks
        en = 1'b1; ch_en = 4'b0001; up_dn = 1'b1; cascade = 1'b0; sel = 2'd0;
        expect_at(1, S_SEG4, 8'h3F, "up_seg_e1");
        expect_at(2, S_SEG4, 8'h06, "up_seg_e2");
        expect_at(3, S_SEG4, 8'h5B, "up_seg_e3");
        expect_at(4, S_SEG4, 8'h4F, "up_seg_e4");
        expect_at(4, S_DP4,  8'h00, "up_dp_e4");
        expect_at(4, S_SEG3, 8'h4F, "up_seg3_e4");
        nclk(3);
        en = 1'b0;
        nclk(1);
        checks++;
        if (seg4 !== 7'h4F) begin
            failures++;
            $display("FAIL direct_up_seg4 actual=0x%02h required=0x4F", seg4);
        end else begin
            $display("ok   direct_up_seg4 value=0x%02h", seg4);
        end
        sel = 2'd1;
        expect_at(1, S_SEG4, 8'h3F, "ch1_idle");
        nclk(1);

        // Cascade: load every channel to 9, then one tick rolls all over
        cascade = 1'b1; sel = 2'd0; load = 1'b1; load_val = 4'd9;
        for (int k = 0; k < 4; k++) begin
            load_ch = 2'(k);
            nclk(1);
        end
        load = 1'b0; en = 1'b1;
        expect_at(1, S_SEG4, 8'h6F, "casc_pre_seg");
        expect_at(1, S_DP4,  8'h01, "casc_pre_dp");
        expect_at(1, S_CRY4, 8'h01, "casc_carry_hi");
        expect_at(1, S_CRY3, 8'h01, "casc_carry3_hi");
        nclk(1);
        en = 1'b0;
        expect_at(1, S_SEG4, 8'h3F, "casc_ch0_zero");
        expect_at(1, S_DP4,  8'h00, "casc_dp_off");
        expect_at(1, S_CRY4, 8'h00, "casc_carry_lo");
        expect_at(1, S_CRY3, 8'h00, "casc_carry3_lo");
        nclk(1);
        sel = 2'd3;
        expect_at(1, S_SEG4, 8'h3F, "casc_ch3_zero");
        nclk(1);

        // Down-count wrap 0 -> 9
        cascade = 1'b0; ch_en = 4'b0001; up_dn = 1'b0; sel = 2'd0; en = 1'b1;
        expect_at(1, S_SEG4, 8'h3F, "down_pre_seg");
        expect_at(1, S_CRY4, 8'h00, "down_no_carry");
        nclk(1);
        en = 1'b0;
        expect_at(1, S_SEG4, 8'h6F, "down_wrap_seg");
        expect_at(1, S_DP4,  8'h01, "down_wrap_dp");
        nclk(1);

        // Saturating load wins over a step on ch2; ch0 steps 9 -> 0 alongside
        up_dn = 1'b1; ch_en = 4'b0101; en = 1'b1; sel = 2'd2;
        load = 1'b1; load_ch = 2'd2; load_val = 4'd12;
        expect_at(1, S_SEG4, 8'h3F, "load_pre_seg");
        nclk(1);
        load = 1'b0; en = 1'b0;
        expect_at(1, S_SEG4, 8'h6F, "load_sat_seg");
        expect_at(1, S_DP4,  8'h01, "load_sat_dp");
        expect_at(1, S_SEG3, 8'h6F, "load_sat_seg3");
        nclk(1);
        sel = 2'd0;
        expect_at(1, S_SEG4, 8'h3F, "load_other_step");
        expect_at(1, S_DP4,  8'h00, "load_other_dp");
        nclk(1);

        // Out-of-range select on the 3-channel instance
        sel = 2'd3;
        expect_at(1, S_SEG3, 8'h00, "oor_seg3_blank");
        expect_at(1, S_DP3,  8'h00, "oor_dp3_off");
        expect_at(1, S_SEG4, 8'h3F, "sel3_seg4");
        expect_at(1, S_DIG4, 8'h03, "sel3_dig4");
        nclk(1);
        checks++;
        if (seg3 !== 7'h00) begin
            failures++;
            $display("FAIL direct_oor_seg3 actual=0x%02h required=0x00", seg3);
        end else begin
            $display("ok   direct_oor_seg3 value=0x%02h", seg3);
        end

        // Auto-scan, two clocks per channel
        scan_en = 1'b1;
        expect_at(1, S_DIG3, 8'h00, "scan3_1");
        expect_at(2, S_DIG3, 8'h00, "scan3_2");
        expect_at(3, S_DIG3, 8'h01, "scan3_3");
        expect_at(4, S_DIG3, 8'h01, "scan3_4");
        expect_at(5, S_DIG3, 8'h02, "scan3_5");
        expect_at(6, S_DIG3, 8'h02, "scan3_6");
        expect_at(7, S_DIG3, 8'h00, "scan3_7");
        expect_at(5, S_SEG4, 8'h6F, "scan4_ch2_seg");
        expect_at(5, S_SEG3, 8'h6F, "scan3_ch2_seg");
        expect_at(7, S_DIG4, 8'h03, "scan4_7");
        expect_at(9, S_DIG4, 8'h00, "scan4_9");
        nclk(9);

        // Reset mid-count, mid-scan and mid-load
        en = 1'b1; ch_en = 4'b1111; rst = 1'b1;
        load = 1'b1; load_ch = 2'd2; load_val = 4'd5;
        expect_at(1, S_SEG4, 8'h00, "mrst_seg4");
        expect_at(1, S_DP4,  8'h00, "mrst_dp4");
        expect_at(1, S_DIG4, 8'h00, "mrst_dig4");
        expect_at(1, S_CRY4, 8'h00, "mrst_carry4");
        expect_at(1, S_SEG3, 8'h00, "mrst_seg3");
        expect_at(1, S_DIG3, 8'h00, "mrst_dig3");
        nclk(1);
        checks++;
        if (seg4 !== 7'h00) begin
            failures++;
            $display("FAIL direct_mrst_seg4 actual=0x%02h required=0x00", seg4);
        end else begin
            $display("ok   direct_mrst_seg4 value=0x%02h", seg4);
        end
        checks++;
        if (dig4 !== 2'd0) begin
            failures++;
            $display("FAIL direct_mrst_dig4 actual=%0d required=0", dig4);
        end else begin
            $display("ok   direct_mrst_dig4 value=%0d", dig4);
        end
        checks++;
        if (carry4 !== 1'b0) begin
            failures++;
            $display("FAIL direct_mrst_carry4 actual=%0b required=0", carry4);
        end else begin
            $display("ok   direct_mrst_carry4 value=%0b", carry4);
        end
        rst = 1'b0; load = 1'b0; en = 1'b0; scan_en = 1'b0; sel = 2'd2;
        expect_at(1, S_SEG4, 8'h3F, "mrst_ch2_zero");
        expect_at(1, S_DIG4, 8'h02, "mrst_sel_dig4");
        nclk(1);

        for (int w = 0; w < 10 && sb.size() > 0; w++) nclk(1);
        while (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s never_checked actual=none required=0x%02h", sb[0].name, sb[0].exp);
            void'(sb.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
